// File: rtl/sd_card_cmd_responder_if.sv
// CMD-line and card-logic signals of the SD command responder.
// The slave modport is the responder itself; master is the host/card-logic side.
interface sd_card_cmd_responder_if;
  logic         in_sd_cmd;
  logic         out_sd_cmd;
  logic         out_sd_cmd_oe;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic         cmd_valid;
  logic         cmd_crc_err;
  logic         in_resp_valid;
  logic         in_resp_none;
  logic         in_resp_long;
  logic         in_resp_nocrc;
  logic [5:0]   in_resp_index;
  logic [127:0] in_resp_data;
  logic         resp_drop;
  logic         busy;

  modport slave (
    input  in_sd_cmd, in_resp_valid, in_resp_none, in_resp_long, in_resp_nocrc,
           in_resp_index, in_resp_data,
    output out_sd_cmd, out_sd_cmd_oe, cmd_index, cmd_arg, cmd_valid, cmd_crc_err,
           resp_drop, busy
  );

  modport master (
    output in_sd_cmd, in_resp_valid, in_resp_none, in_resp_long, in_resp_nocrc,
           in_resp_index, in_resp_data,
    input  out_sd_cmd, out_sd_cmd_oe, cmd_index, cmd_arg, cmd_valid, cmd_crc_err,
           resp_drop, busy
  );
endinterface

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line: receives 48-bit host commands, checks framing/CRC7,
// and serialises a 48-bit or 136-bit response after the NCR gap.
module sd_card_cmd_responder #(
  parameter int unsigned NCR      = 2,
  parameter int unsigned MAX_WAIT = 60
) (
  input logic                    in_sd_clk,
  input logic                    hrst_n,
  input logic                    in_soft_reset,
  sd_card_cmd_responder_if.slave bus
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {StIdle, StRecv, StCheck, StWaitResp, StSend} state_e;

  state_e             state_q, state_d;
  logic [47:0]        rx_q, rx_d;
  logic [5:0]         rx_cnt_q, rx_cnt_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic               cap_q, cap_d;
  logic               long_q, long_d;
  logic               nocrc_q, nocrc_d;
  logic [135:0]       tx_q, tx_d;
  logic [7:0]         tx_cnt_q, tx_cnt_d;
  logic [6:0]         crc_q, crc_d;
  logic               out_q, out_d;
  logic               oe_q, oe_d;
  logic [5:0]         idx_q, idx_d;
  logic [31:0]        arg_q, arg_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               drop_q, drop_d;

  logic               rx_ok;
  logic               live;
  logic               tx_bit;
  logic [7:0]         tx_pos;
  logic [7:0]         tx_last;

  function automatic logic [6:0] crc7_step(logic [6:0] crc, logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_calc(logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  assign rx_ok = rx_q[46] && rx_q[0] && (crc7_calc(rx_q[47:8]) == rx_q[7:1]);

  // Next-state and datapath decode.
  always_comb begin
    state_d    = state_q;
    rx_d       = rx_q;
    rx_cnt_d   = rx_cnt_q;
    wait_cnt_d = wait_cnt_q;
    cap_d      = cap_q;
    long_d     = long_q;
    nocrc_d    = nocrc_q;
    tx_d       = tx_q;
    tx_cnt_d   = tx_cnt_q;
    crc_d      = crc_q;
    out_d      = out_q;
    oe_d       = oe_q;
    idx_d      = idx_q;
    arg_d      = arg_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    drop_d     = 1'b0;
    live       = bus.in_resp_valid && !cap_q;
    tx_bit     = 1'b1;
    tx_pos     = tx_cnt_q + 8'd1;
    tx_last    = long_q ? 8'd135 : 8'd47;

    unique case (state_q)
      StIdle: begin
        if (!bus.in_sd_cmd) begin
          rx_d     = '0;
          rx_cnt_d = 6'd1;
          state_d  = StRecv;
        end
      end
      StRecv: begin
        rx_d     = {rx_q[46:0], bus.in_sd_cmd};
        rx_cnt_d = rx_cnt_q + 6'd1;
        if (rx_cnt_q == 6'd47) state_d = StCheck;
      end
      StCheck: begin
        if (rx_ok) begin
          valid_d    = 1'b1;
          idx_d      = rx_q[45:40];
          arg_d      = rx_q[39:8];
          wait_cnt_d = '0;
          cap_d      = 1'b0;
          state_d    = StWaitResp;
        end else begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StWaitResp: begin
        if (wait_cnt_q != WaitW'(MAX_WAIT)) wait_cnt_d = wait_cnt_q + 1'b1;
        if (live && bus.in_resp_none) begin
          state_d = StIdle;
        end else begin
          if (live) begin
            cap_d   = 1'b1;
            long_d  = bus.in_resp_long;
            nocrc_d = bus.in_resp_nocrc;
            // Frame bits after the start bit, left-aligned; short CRC/end overlaid in SEND.
            if (bus.in_resp_long) begin
              tx_d = {1'b0, 6'h3F, bus.in_resp_data[127:1], 1'b1, 1'b0};
            end else begin
              tx_d = {1'b0, bus.in_resp_nocrc ? 6'h3F : bus.in_resp_index,
                      bus.in_resp_data[31:0], 97'b0};
            end
          end
          // Launch on the edge ending the last NCR gap cycle, or right after capture.
          if ((cap_q || live) && (wait_cnt_q >= WaitW'(NCR - 2))) begin
            state_d  = StSend;
            out_d    = 1'b0;
            oe_d     = 1'b1;
            tx_cnt_d = '0;
            crc_d    = '0;
          end else if (!cap_q && !live && (wait_cnt_q == WaitW'(MAX_WAIT - 1))) begin
            drop_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StSend: begin
        if (tx_cnt_q == tx_last) begin
          state_d = StIdle;
          out_d   = 1'b1;
          oe_d    = 1'b0;
        end else begin
          tx_cnt_d = tx_pos;
          if (!long_q && (tx_pos >= 8'd40)) begin
            tx_bit = (tx_pos == 8'd47) ? 1'b1 : (nocrc_q | crc_q[6]);
            crc_d  = {crc_q[5:0], 1'b0};
          end else begin
            tx_bit = tx_q[135];
            tx_d   = {tx_q[134:0], 1'b0};
            if (!long_q) crc_d = crc7_step(crc_q, tx_bit);
          end
          out_d = tx_bit;
        end
      end
      default: state_d = StIdle;
    endcase

    // Synchronous soft reset has the same effect as hrst_n.
    if (!in_soft_reset) begin
      state_d    = StIdle;
      rx_d       = '0;
      rx_cnt_d   = '0;
      wait_cnt_d = '0;
      cap_d      = 1'b0;
      long_d     = 1'b0;
      nocrc_d    = 1'b0;
      tx_d       = '0;
      tx_cnt_d   = '0;
      crc_d      = '0;
      out_d      = 1'b1;
      oe_d       = 1'b0;
      idx_d      = '0;
      arg_d      = '0;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      drop_d     = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge in_sd_clk or negedge hrst_n) begin
    if (!hrst_n) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Datapath and registered outputs.
  always_ff @(posedge in_sd_clk or negedge hrst_n) begin
    if (!hrst_n) begin
      rx_q       <= '0;
      rx_cnt_q   <= '0;
      wait_cnt_q <= '0;
      cap_q      <= 1'b0;
      long_q     <= 1'b0;
      nocrc_q    <= 1'b0;
      tx_q       <= '0;
      tx_cnt_q   <= '0;
      crc_q      <= '0;
      out_q      <= 1'b1;
      oe_q       <= 1'b0;
      idx_q      <= '0;
      arg_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      rx_q       <= rx_d;
      rx_cnt_q   <= rx_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      cap_q      <= cap_d;
      long_q     <= long_d;
      nocrc_q    <= nocrc_d;
      tx_q       <= tx_d;
      tx_cnt_q   <= tx_cnt_d;
      crc_q      <= crc_d;
      out_q      <= out_d;
      oe_q       <= oe_d;
      idx_q      <= idx_d;
      arg_q      <= arg_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.out_sd_cmd    = out_q;
  assign bus.out_sd_cmd_oe = oe_q;
  assign bus.cmd_index     = idx_q;
  assign bus.cmd_arg       = arg_q;
  assign bus.cmd_valid     = valid_q;
  assign bus.cmd_crc_err   = err_q;
  assign bus.resp_drop     = drop_q;
  assign bus.busy          = (state_q != StIdle);

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Directed bench for sd_card_cmd_responder: drives host commands on CMD and
// checks decode, response framing/timing, drop timeout and soft reset.
module tb_sd_card_cmd_responder;

  logic in_sd_clk = 1'b0;
  logic hrst_n;
  logic in_soft_reset;

  sd_card_cmd_responder_if bus ();

  sd_card_cmd_responder #(
    .NCR      (2),
    .MAX_WAIT (60)
  ) dut (
    .in_sd_clk     (in_sd_clk),
    .hrst_n        (hrst_n),
    .in_soft_reset (in_soft_reset),
    .bus           (bus)
  );

  always #5 in_sd_clk = ~in_sd_clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(string tag, logic [135:0] got, logic [135:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC7 x^7+x^3+1, MSB first, init 0.
  function automatic logic [6:0] crc7(logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    end
    return c;
  endfunction

  // Drives the frame starting at the current negedge; returns one cycle after the end bit.
  task automatic send_frame(logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      bus.in_sd_cmd = f[i];
      @(negedge in_sd_clk);
    end
    bus.in_sd_cmd = 1'b1;
  endtask

  task automatic pulse_resp(logic none, logic lng, logic nocrc, logic [5:0] idx,
                            logic [127:0] data);
    bus.in_resp_valid = 1'b1;
    bus.in_resp_none  = none;
    bus.in_resp_long  = lng;
    bus.in_resp_nocrc = nocrc;
    bus.in_resp_index = idx;
    bus.in_resp_data  = data;
    @(negedge in_sd_clk);
    bus.in_resp_valid = 1'b0;
    bus.in_resp_none  = 1'b0;
    bus.in_resp_long  = 1'b0;
    bus.in_resp_nocrc = 1'b0;
  endtask

  // First sample taken at the current negedge.
  task automatic get_resp(int n, output logic [135:0] r, output int oe_n);
    r    = '0;
    oe_n = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge in_sd_clk);
      r = {r[134:0], bus.out_sd_cmd};
      if (bus.out_sd_cmd_oe) oe_n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [135:0] r;
    logic [135:0] exp;
    logic [39:0]  c2;
    logic [127:0] cid;
    int           oen;
    int           lat;
    int           oes;

    hrst_n            = 1'b0;
    in_soft_reset     = 1'b1;
    bus.in_sd_cmd     = 1'b1;
    bus.in_resp_valid = 1'b0;
    bus.in_resp_none  = 1'b0;
    bus.in_resp_long  = 1'b0;
    bus.in_resp_nocrc = 1'b0;
    bus.in_resp_index = '0;
    bus.in_resp_data  = '0;
    repeat (3) @(negedge in_sd_clk);
    check_eq("rst_cmd", bus.out_sd_cmd, 1'b1);
    check_eq("rst_oe", bus.out_sd_cmd_oe, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_idx", bus.cmd_index, 6'd0);
    check_eq("rst_arg", bus.cmd_arg, 32'd0);
    hrst_n = 1'b1;
    @(negedge in_sd_clk);

    // CMD0, no response.
    send_frame({40'h40_0000_0000, 8'h95});
    @(negedge in_sd_clk);
    check_eq("cmd0_valid", bus.cmd_valid, 1'b1);
    check_eq("cmd0_idx", bus.cmd_index, 6'd0);
    check_eq("cmd0_arg", bus.cmd_arg, 32'd0);
    check_eq("cmd0_busy", bus.busy, 1'b1);
    pulse_resp(1'b1, 1'b0, 1'b0, 6'd0, 128'd0);
    check_eq("cmd0_pulse1", bus.cmd_valid, 1'b0);
    check_eq("cmd0_idle", bus.busy, 1'b0);
    oes = 0;
    repeat (5) begin
      @(negedge in_sd_clk);
      if (bus.out_sd_cmd_oe) oes++;
    end
    check_eq("cmd0_no_oe", 136'(oes), 136'(0));

    // CMD8, R7 short response given with cmd_valid.
    @(negedge in_sd_clk);
    send_frame({40'h48_0000_01AA, 8'h87});
    @(negedge in_sd_clk);
    check_eq("cmd8_valid", bus.cmd_valid, 1'b1);
    check_eq("cmd8_idx", bus.cmd_index, 6'd8);
    check_eq("cmd8_arg", bus.cmd_arg, 32'h1AA);
    check_eq("cmd8_gap_oe", bus.out_sd_cmd_oe, 1'b0);
    pulse_resp(1'b0, 1'b0, 1'b0, 6'd8, 128'h1AA);
    get_resp(48, r, oen);
    exp = {88'd0, 2'b00, 6'd8, 32'h1AA, crc7({2'b00, 6'd8, 32'h1AA}), 1'b1};
    check_eq("cmd8_resp", r, exp);
    check_eq("cmd8_oe_len", 136'(oen), 136'(48));
    @(negedge in_sd_clk);
    check_eq("cmd8_end_oe", bus.out_sd_cmd_oe, 1'b0);
    check_eq("cmd8_end_cmd", bus.out_sd_cmd, 1'b1);

    // CMD2 back-to-back: start bit on the first idle cycle, R2 long response.
    c2  = 40'h42_0000_0000;
    cid = 128'h0353_4453_4430_3847_8012_3456_7800_C1E5;
    send_frame({c2, crc7(c2), 1'b1});
    @(negedge in_sd_clk);
    check_eq("cmd2_valid", bus.cmd_valid, 1'b1);
    check_eq("cmd2_idx", bus.cmd_index, 6'd2);
    pulse_resp(1'b0, 1'b1, 1'b0, 6'd2, cid);
    get_resp(136, r, oen);
    exp = {2'b00, 6'h3F, cid[127:1], 1'b1};
    check_eq("cmd2_resp", r, exp);
    check_eq("cmd2_oe_len", 136'(oen), 136'(136));
    @(negedge in_sd_clk);
    check_eq("cmd2_end_oe", bus.out_sd_cmd_oe, 1'b0);

    // CMD55 with corrupted CRC byte.
    @(negedge in_sd_clk);
    send_frame({40'h77_0000_0000, 8'h64});
    @(negedge in_sd_clk);
    check_eq("cmd55_err", bus.cmd_crc_err, 1'b1);
    check_eq("cmd55_valid", bus.cmd_valid, 1'b0);
    check_eq("cmd55_busy", bus.busy, 1'b0);
    check_eq("cmd55_idx_held", bus.cmd_index, 6'd2);
    @(negedge in_sd_clk);
    check_eq("cmd55_err_pulse", bus.cmd_crc_err, 1'b0);

    // ACMD41 without response: drop after MAX_WAIT.
    @(negedge in_sd_clk);
    send_frame({40'h69_4000_0000, 8'h77});
    @(negedge in_sd_clk);
    check_eq("acmd41_valid", bus.cmd_valid, 1'b1);
    check_eq("acmd41_idx", bus.cmd_index, 6'd41);
    lat = -1;
    oes = 0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge in_sd_clk);
      if (bus.out_sd_cmd_oe) oes++;
      if (bus.resp_drop) begin
        lat = i;
        break;
      end
    end
    check_eq("drop_latency", 136'(lat), 136'(60));
    check_eq("drop_no_oe", 136'(oes), 136'(0));
    @(negedge in_sd_clk);
    check_eq("drop_idle", bus.busy, 1'b0);
    check_eq("drop_pulse", bus.resp_drop, 1'b0);

    // ACMD41 with R3 given at wait count 10.
    @(negedge in_sd_clk);
    send_frame({40'h69_4000_0000, 8'h77});
    @(negedge in_sd_clk);
    check_eq("r3_valid", bus.cmd_valid, 1'b1);
    repeat (10) @(negedge in_sd_clk);
    check_eq("r3_pre_oe", bus.out_sd_cmd_oe, 1'b0);
    pulse_resp(1'b0, 1'b0, 1'b1, 6'd41, 128'h80FF_8000);
    check_eq("r3_start_oe", bus.out_sd_cmd_oe, 1'b1);
    get_resp(48, r, oen);
    exp = {88'd0, 2'b00, 6'h3F, 32'h80FF_8000, 7'h7F, 1'b1};
    check_eq("r3_resp", r, exp);
    check_eq("r3_oe_len", 136'(oen), 136'(48));

    // Soft reset during response bit 20, then CMD0 decodes again.
    @(negedge in_sd_clk);
    @(negedge in_sd_clk);
    send_frame({40'h48_0000_01AA, 8'h87});
    @(negedge in_sd_clk);
    pulse_resp(1'b0, 1'b0, 1'b0, 6'd8, 128'h1AA);
    repeat (20) @(negedge in_sd_clk);
    check_eq("srst_pre_oe", bus.out_sd_cmd_oe, 1'b1);
    in_soft_reset = 1'b0;
    @(negedge in_sd_clk);
    check_eq("srst_oe", bus.out_sd_cmd_oe, 1'b0);
    check_eq("srst_cmd", bus.out_sd_cmd, 1'b1);
    check_eq("srst_busy", bus.busy, 1'b0);
    check_eq("srst_idx", bus.cmd_index, 6'd0);
    check_eq("srst_arg", bus.cmd_arg, 32'd0);
    in_soft_reset = 1'b1;
    @(negedge in_sd_clk);
    send_frame({40'h40_0000_0000, 8'h95});
    @(negedge in_sd_clk);
    check_eq("post_cmd0_valid", bus.cmd_valid, 1'b1);
    check_eq("post_cmd0_err", bus.cmd_crc_err, 1'b0);
    pulse_resp(1'b1, 1'b0, 1'b0, 6'd0, 128'd0);
    check_eq("post_cmd0_idle", bus.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
